// File: rtl/day_seq_ctrl_if.sv
// day_seq_ctrl_if: control inputs and display outputs of the day sequencer.
interface day_seq_ctrl_if;
    logic       run;
    logic       step;
    logic       load;
    logic [2:0] load_day;
    logic [2:0] day;
    logic       day_tick;
    logic [6:0] seg;
    logic [1:0] dig_en;

    modport master (
        output run, step, load, load_day,
        input  day, day_tick, seg, dig_en
    );

    modport slave (
        input  run, step, load, load_day,
        output day, day_tick, seg, dig_en
    );
endinterface

// File: rtl/day_seq_ctrl.sv
// day_seq_ctrl: owns the current day, advances it by prescaler/step/load and
// multiplexes its letter and number onto a shared 7-segment bus.
module day_seq_ctrl #(
    parameter int TICK_DIV = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    day_seq_ctrl_if.slave  bus_if
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRES_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    // Index 7 is unreachable; the blank entry keeps the tables fully indexed.
    localparam logic [7:0][6:0] LETTER = {
        7'b0000000, 7'b1011011, 7'b1011011, 7'b1000111,
        7'b1110000, 7'b0001110, 7'b1110000, 7'b1100110
    };
    localparam logic [7:0][6:0] NUMBER = {
        7'b0000000, 7'b1110000, 7'b1011111, 7'b1011011,
        7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000
    };

    logic [PW-1:0] pres_q, pres_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [2:0]    day_q, day_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_en_q, dig_en_d;
    logic          step_q, tick_q, tick_d, sel_q, sel_d;
    logic          auto_adv, man_adv;

    always_comb begin
        auto_adv = bus_if.run && (pres_q == PRES_MAX);
        man_adv  = bus_if.step && !step_q && !bus_if.run;
        pres_d   = bus_if.load ? '0 : !bus_if.run ? pres_q : auto_adv ? '0 : pres_q + 1'b1;
        day_d    = bus_if.load ? (bus_if.load_day == 3'd7 ? 3'd0 : bus_if.load_day)
                 : (auto_adv || man_adv) ? (day_q == 3'd6 ? 3'd0 : day_q + 3'd1)
                 : day_q;
        tick_d   = !bus_if.load && (auto_adv || man_adv);
        scnt_d   = scnt_q == SCAN_MAX ? '0 : scnt_q + 1'b1;
        sel_d    = sel_q ^ (scnt_q == SCAN_MAX);
        dig_en_d = sel_d ? 2'b10 : 2'b01;
        seg_d    = sel_d ? NUMBER[day_d] : LETTER[day_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q   <= '0;
            scnt_q   <= '0;
            day_q    <= 3'd0;
            seg_q    <= 7'd0;
            dig_en_q <= 2'b00;
            step_q   <= 1'b0;
            tick_q   <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            pres_q   <= pres_d;
            scnt_q   <= scnt_d;
            day_q    <= day_d;
            seg_q    <= seg_d;
            dig_en_q <= dig_en_d;
            step_q   <= bus_if.step;
            tick_q   <= tick_d;
            sel_q    <= sel_d;
        end
    end

    assign bus_if.day      = day_q;
    assign bus_if.day_tick = tick_q;
    assign bus_if.seg      = seg_q;
    assign bus_if.dig_en   = dig_en_q;
endmodule

// File: tb/tb_day_seq_ctrl.sv
// tb_day_seq_ctrl: directed scenarios for day_seq_ctrl with default parameters.
module tb_day_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    day_seq_ctrl_if bus();

    day_seq_ctrl #(.TICK_DIV(3), .SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.step = 1'b0; bus.load = 1'b0; bus.load_day = 3'd0;
        @(negedge clk);
        n_checks++;
        if (bus.day !== 3'd0 || bus.day_tick !== 1'b0 || bus.seg !== 7'd0 || bus.dig_en !== 2'b00) begin
            n_fail++;
            $display("FAIL reset: day=%0d tick=%b seg=%b dig_en=%b expected 0 0 0000000 00",
                     bus.day, bus.day_tick, bus.seg, bus.dig_en);
        end
        bus.run = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_auto();
        int ticks = 0;
        for (int k = 1; k <= 21; k++) begin
            edge1();
            if (k == 1) begin
                n_checks++;
                if (bus.dig_en !== 2'b01 || bus.seg !== 7'b1100110) begin
                    n_fail++;
                    $display("FAIL first_edge: dig_en=%b seg=%b expected 01 1100110", bus.dig_en, bus.seg);
                end
            end
            n_checks++;
            if (bus.day !== 3'((k / 3) % 7) || bus.day_tick !== (k % 3 == 0)) begin
                n_fail++;
                $display("FAIL auto edge %0d: day=%0d tick=%b expected %0d %b",
                         k, bus.day, bus.day_tick, (k / 3) % 7, (k % 3 == 0));
            end
            ticks += int'(bus.day_tick);
        end
        n_checks++;
        if (ticks != 7) begin
            n_fail++;
            $display("FAIL auto ticks: got %0d expected 7", ticks);
        end
    endtask

    task automatic test_step();
        int ticks = 0;
        bus.run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.step = (i < 10 || i == 12);
            edge1();
            ticks += int'(bus.day_tick);
            if (i == 0) begin
                n_checks++;
                if (bus.day !== 3'd1) begin
                    n_fail++;
                    $display("FAIL step latency: day=%0d expected 1", bus.day);
                end
            end
        end
        n_checks++;
        if (bus.day !== 3'd2 || ticks != 2) begin
            n_fail++;
            $display("FAIL step count: day=%0d ticks=%0d expected 2 2", bus.day, ticks);
        end
    endtask

    task automatic test_load_collide();
        bus.run = 1'b1;
        edge1();
        edge1();
        n_checks++;
        if (bus.day !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_load: day=%0d expected 2", bus.day);
        end
        bus.load = 1'b1; bus.load_day = 3'd4;
        edge1();
        bus.load = 1'b0;
        n_checks++;
        if (bus.day !== 3'd4 || bus.day_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL load_collide: day=%0d tick=%b expected 4 0", bus.day, bus.day_tick);
        end
        for (int k = 1; k <= 3; k++) begin
            edge1();
            n_checks++;
            if (bus.day !== (k == 3 ? 3'd5 : 3'd4) || bus.day_tick !== (k == 3)) begin
                n_fail++;
                $display("FAIL load_restart %0d: day=%0d tick=%b expected %0d %b",
                         k, bus.day, bus.day_tick, (k == 3 ? 5 : 4), (k == 3));
            end
        end
    endtask

    task automatic test_load7();
        bit seen0 = 0, seen1 = 0;
        bus.run = 1'b0; bus.load = 1'b1; bus.load_day = 3'd7;
        edge1();
        bus.load = 1'b0;
        n_checks++;
        if (bus.day !== 3'd0) begin
            n_fail++;
            $display("FAIL load7: day=%0d expected 0", bus.day);
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.dig_en === 2'b01 && !seen0) begin
                seen0 = 1;
                n_checks++;
                if (bus.seg !== 7'b1100110) begin
                    n_fail++;
                    $display("FAIL load7 digit0 seg=%b expected 1100110", bus.seg);
                end
            end
            if (bus.dig_en === 2'b10 && !seen1) begin
                seen1 = 1;
                n_checks++;
                if (bus.seg !== 7'b0110000) begin
                    n_fail++;
                    $display("FAIL load7 digit1 seg=%b expected 0110000", bus.seg);
                end
            end
            edge1();
        end
        n_checks++;
        if (!(seen0 && seen1)) begin
            n_fail++;
            $display("FAIL load7 scan timeout: seen0=%b seen1=%b expected 1 1", seen0, seen1);
        end
    endtask

    task automatic test_scan();
        logic [1:0] d[24];
        int first = -1;
        bus.load = 1'b1; bus.load_day = 3'd5;
        edge1();
        bus.load = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d[i] = bus.dig_en;
            n_checks++;
            if (bus.seg !== (bus.dig_en === 2'b10 ? 7'b1011111 : 7'b1011011) ||
                (bus.dig_en !== 2'b01 && bus.dig_en !== 2'b10)) begin
                n_fail++;
                $display("FAIL scan sample %0d: dig_en=%b seg=%b expected onehot with Sat letter/6",
                         i, bus.dig_en, bus.seg);
            end
            edge1();
        end
        for (int i = 1; i < 6; i++)
            if (first < 0 && d[i] !== d[i-1]) first = i;
        n_checks++;
        if (first < 0) begin
            n_fail++;
            $display("FAIL scan no toggle: first=%0d expected >=1", first);
        end else begin
            for (int j = 0; j < 16; j++) begin
                n_checks++;
                if (d[first+j] !== (((j / 4) % 2 == 0) ? d[first] : ~d[first])) begin
                    n_fail++;
                    $display("FAIL scan period %0d: dig_en=%b expected %b", j, d[first+j],
                             ((j / 4) % 2 == 0) ? d[first] : ~d[first]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bus.run = 1'b1; bus.load = 1'b1; bus.load_day = 3'd3;
        edge1();
        bus.load = 1'b0;
        n_checks++;
        if (bus.day !== 3'd3) begin
            n_fail++;
            $display("FAIL async pre: day=%0d expected 3", bus.day);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.day !== 3'd0 || bus.day_tick !== 1'b0 || bus.seg !== 7'd0 || bus.dig_en !== 2'b00) begin
            n_fail++;
            $display("FAIL async reset: day=%0d tick=%b seg=%b dig_en=%b expected 0 0 0000000 00",
                     bus.day, bus.day_tick, bus.seg, bus.dig_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            edge1();
            n_checks++;
            if (bus.day !== (k == 3 ? 3'd1 : 3'd0) || bus.day_tick !== (k == 3)) begin
                n_fail++;
                $display("FAIL async restart %0d: day=%0d tick=%b expected %0d %b",
                         k, bus.day, bus.day_tick, (k == 3 ? 1 : 0), (k == 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_step();
        test_load_collide();
        test_load7();
        test_scan();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
